// File: rtl/ddr_cmd_arbiter_if.sv
// rtl/ddr_cmd_arbiter_if.sv - requester/MCB signal bundle for ddr_cmd_arbiter
// master = requesters + MCB side, slave = the arbiter.
interface ddr_cmd_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              calib_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_burst_done;
  logic [6:0]        mcb_wr_count;
  logic              mcb_cmd_full;
  logic              mcb_cmd_en;
  logic [2:0]        mcb_cmd_instr;
  logic [5:0]        mcb_cmd_bl;
  logic [ADDR_W-1:0] mcb_cmd_byte_addr;
  logic              arb_busy;

  modport master (
    output calib_done, wr_req, wr_addr, rd_req, rd_addr, rd_burst_done,
           mcb_wr_count, mcb_cmd_full,
    input  wr_ack, rd_ack, mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl,
           mcb_cmd_byte_addr, arb_busy
  );

  modport slave (
    input  calib_done, wr_req, wr_addr, rd_req, rd_addr, rd_burst_done,
           mcb_wr_count, mcb_cmd_full,
    output wr_ack, rd_ack, mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl,
           mcb_cmd_byte_addr, arb_busy
  );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// rtl/ddr_cmd_arbiter.sv - MCB command port arbiter: write priority, read anti-starvation, read in-flight cap
// Optional grant/stall statistics counters are built when DDR_ARB_STATS_EN is defined.
module ddr_cmd_arbiter #(
  parameter int BL            = 64,
  parameter int ADDR_W        = 30,
  parameter int WR_MAX_CONSEC = 4,
  parameter int RD_MAX_OUTST  = 2,
  parameter int STATS_W       = 16
) (
  input  logic             ddr_usrclk,
  input  logic             reset_n,
  ddr_cmd_arbiter_if.slave bus
`ifdef DDR_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [STATS_W-1:0] stat_wr_grants,
  output logic [STATS_W-1:0] stat_rd_grants,
  output logic [STATS_W-1:0] stat_stall_cycles
`endif
);

  if (BL < 1 || BL > 64 || STATS_W < 1 || WR_MAX_CONSEC < 1 || RD_MAX_OUTST < 1) begin : g_bad_param
    $error("ddr_cmd_arbiter: parameter out of range");
  end

  localparam int WC_W = $clog2(WR_MAX_CONSEC + 1);
  localparam int RO_W = $clog2(RD_MAX_OUTST + 1);
  localparam logic [WC_W-1:0]   WC_MAX    = WC_W'(WR_MAX_CONSEC);
  localparam logic [RO_W-1:0]   RO_MAX    = RO_W'(RD_MAX_OUTST);
  localparam logic [6:0]        BL_CNT    = 7'(BL);
  localparam logic [5:0]        BL_M1     = 6'(BL - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t            state;
  logic [WC_W-1:0]   wr_consec;
  logic [RO_W-1:0]   rd_outst;
  logic              cmd_en_r, wr_ack_r, rd_ack_r, busy_r;
  logic [2:0]        instr_r;
  logic [5:0]        bl_r;
  logic [ADDR_W-1:0] addr_r;

  logic wr_elig, rd_elig, pick_rd, issue_fire, wr_issue, rd_issue;

  assign wr_elig    = bus.wr_req & (bus.mcb_wr_count >= BL_CNT);
  assign rd_elig    = bus.rd_req & (rd_outst < RO_MAX);
  // Read only overrides a competing write once the write streak hits its limit.
  assign pick_rd    = rd_elig & (~wr_elig | (wr_consec == WC_MAX));
  assign issue_fire = (state == ISSUE) & bus.calib_done & ~bus.mcb_cmd_full;
  assign wr_issue   = issue_fire & ~instr_r[0];
  assign rd_issue   = issue_fire & instr_r[0];

  assign bus.mcb_cmd_en        = cmd_en_r;
  assign bus.wr_ack            = wr_ack_r;
  assign bus.rd_ack            = rd_ack_r;
  assign bus.mcb_cmd_instr     = instr_r;
  assign bus.mcb_cmd_bl        = bl_r;
  assign bus.mcb_cmd_byte_addr = addr_r;
  assign bus.arb_busy          = busy_r;

  always_ff @(posedge ddr_usrclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd_en_r <= 1'b0;
      wr_ack_r <= 1'b0;
      rd_ack_r <= 1'b0;
      busy_r   <= 1'b0;
      instr_r  <= 3'b000;
      addr_r   <= '0;
      bl_r     <= BL_M1;
    end else begin
      cmd_en_r <= 1'b0;
      wr_ack_r <= 1'b0;
      rd_ack_r <= 1'b0;
      bl_r     <= BL_M1;
      case (state)
        IDLE: begin
          if (bus.calib_done & (wr_elig | rd_elig)) begin
            state   <= ISSUE;
            busy_r  <= 1'b1;
            instr_r <= pick_rd ? 3'b001 : 3'b000;
            addr_r  <= (pick_rd ? bus.rd_addr : bus.wr_addr) & ADDR_MASK;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ISSUE: begin
          // Losing calibration abandons the slot without acking; the requester keeps req high.
          if (!bus.calib_done) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (!bus.mcb_cmd_full) begin
            state    <= GAP;
            cmd_en_r <= 1'b1;
            wr_ack_r <= ~instr_r[0];
            rd_ack_r <= instr_r[0];
          end
        end
        GAP: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ddr_usrclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_consec <= '0;
      rd_outst  <= '0;
    end else begin
      if (rd_issue)
        wr_consec <= '0;
      else if (wr_issue && wr_consec != WC_MAX)
        wr_consec <= wr_consec + 1'b1;

      if (rd_issue && !bus.rd_burst_done)
        rd_outst <= rd_outst + 1'b1;
      else if (!rd_issue && bus.rd_burst_done && rd_outst != '0)
        rd_outst <= rd_outst - 1'b1;
    end
  end

`ifdef DDR_ARB_STATS_EN
  localparam logic [STATS_W-1:0] STAT_MAX = '1;

  always_ff @(posedge ddr_usrclk or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_grants    <= '0;
      stat_rd_grants    <= '0;
      stat_stall_cycles <= '0;
    end else if (stat_clr) begin
      stat_wr_grants    <= '0;
      stat_rd_grants    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (wr_issue && stat_wr_grants != STAT_MAX)
        stat_wr_grants <= stat_wr_grants + 1'b1;
      if (rd_issue && stat_rd_grants != STAT_MAX)
        stat_rd_grants <= stat_rd_grants + 1'b1;
      if (state == ISSUE && bus.mcb_cmd_full && stat_stall_cycles != STAT_MAX)
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb/tb_ddr_cmd_arbiter.sv - directed vector bench for ddr_cmd_arbiter
// Stats checks are built only when DDR_ARB_STATS_EN is defined.
module tb_ddr_cmd_arbiter;

  logic ddr_usrclk = 1'b0;
  logic reset_n    = 1'b0;
  always #5 ddr_usrclk = ~ddr_usrclk;

  ddr_cmd_arbiter_if #(.ADDR_W(30)) bus ();

`ifdef DDR_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_wr_grants, stat_rd_grants, stat_stall_cycles;
  ddr_cmd_arbiter dut (.ddr_usrclk(ddr_usrclk), .reset_n(reset_n), .bus(bus),
                       .stat_clr(stat_clr), .stat_wr_grants(stat_wr_grants),
                       .stat_rd_grants(stat_rd_grants), .stat_stall_cycles(stat_stall_cycles));
`else
  ddr_cmd_arbiter dut (.ddr_usrclk(ddr_usrclk), .reset_n(reset_n), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_cmd, n_wr_ack, n_rd_ack;
  logic [2:0]  first_instr;
  logic [29:0] first_addr;
  logic [5:0]  first_bl;
  bit  auto_drop;
  bit  grant_log[$];
  int  grant_cyc[$];

  typedef struct {
    logic        calib, wr_req, rd_req, full;
    logic [6:0]  wr_cnt;
    logic [29:0] wr_addr, rd_addr;
    int          exp_n;
    logic [2:0]  exp_instr;
    logic [29:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_cmd = 0; n_wr_ack = 0; n_rd_ack = 0;
    grant_log.delete();
    grant_cyc.delete();
  endtask

  // One clock; samples 1 time unit after the edge and plays the requester side.
  task automatic tick();
    @(posedge ddr_usrclk);
    #1;
    cyc++;
    if (bus.wr_ack) n_wr_ack++;
    if (bus.rd_ack) n_rd_ack++;
    if (bus.mcb_cmd_en) begin
      if (n_cmd == 0) begin
        first_instr = bus.mcb_cmd_instr;
        first_addr  = bus.mcb_cmd_byte_addr;
        first_bl    = bus.mcb_cmd_bl;
      end
      n_cmd++;
      grant_log.push_back(bus.mcb_cmd_instr[0]);
      grant_cyc.push_back(cyc);
      chk("ack_matches_instr", {30'd0, bus.wr_ack, bus.rd_ack},
          bus.mcb_cmd_instr[0] ? 32'd1 : 32'd2);
    end
    if (auto_drop && bus.wr_ack) bus.wr_req = 1'b0;
    if (auto_drop && bus.rd_ack) bus.rd_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.calib_done = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.rd_burst_done = 1'b0;
    bus.mcb_wr_count = '0; bus.mcb_cmd_full = 1'b0;
`ifdef DDR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) tick();
    reset_n = 1'b1;
    clear_counts();
  endtask

  task automatic wait_issue(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.arb_busy && !bus.mcb_cmd_en) found = 1'b1;
      else tick();
    end
    chk("wait_issue_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    bit found;
    //           calib wr rd full cnt  wr_addr       rd_addr       n  instr   exp_addr
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd64,  30'h103,      30'h0,        1, 3'b000, 30'h100};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd64,  30'h0,        30'h2000_0007, 1, 3'b001, 30'h2000_0004};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd63,  30'h40,       30'h88,       1, 3'b001, 30'h88};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd63,  30'h40,       30'h0,        0, 3'b000, 30'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd64,  30'h10,       30'h20,       2, 3'b000, 30'h10};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd64,  30'h10,       30'h20,       0, 3'b000, 30'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd127, 30'h3FFF_FFFF, 30'h0,       1, 3'b000, 30'h3FFF_FFFC};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd64,  30'h10,       30'h0,        0, 3'b000, 30'h0};

    auto_drop = 1'b1;
    do_reset();
    chk("reset_ctrl", {25'd0, bus.mcb_cmd_en, bus.wr_ack, bus.rd_ack, bus.arb_busy, bus.mcb_cmd_instr},
        32'd0);
    chk("reset_bl", {26'd0, bus.mcb_cmd_bl}, 32'd63);
    chk("reset_addr", {2'd0, bus.mcb_cmd_byte_addr}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      bus.calib_done = vecs[v].calib; bus.wr_req = vecs[v].wr_req; bus.rd_req = vecs[v].rd_req;
      bus.mcb_cmd_full = vecs[v].full; bus.mcb_wr_count = vecs[v].wr_cnt;
      bus.wr_addr = vecs[v].wr_addr; bus.rd_addr = vecs[v].rd_addr;
      repeat (14) tick();
      chk($sformatf("vec%0d_ncmd", v), n_cmd, vecs[v].exp_n);
      chk($sformatf("vec%0d_nack", v), n_wr_ack + n_rd_ack, vecs[v].exp_n);
      if (n_cmd > 0) begin
        chk($sformatf("vec%0d_instr", v), {29'd0, first_instr}, {29'd0, vecs[v].exp_instr});
        chk($sformatf("vec%0d_addr", v), {2'd0, first_addr}, {2'd0, vecs[v].exp_addr});
        chk($sformatf("vec%0d_bl", v), {26'd0, first_bl}, 32'd63);
      end
    end

    // calib_done gating and first-command latency
    do_reset();
    bus.wr_req = 1'b1; bus.mcb_wr_count = 7'd64; bus.wr_addr = 30'h500;
    repeat (20) tick();
    chk("nocalib_ncmd", n_cmd, 0);
    bus.calib_done = 1'b1;
    tick();
    chk("calib_lat1_en", {31'd0, bus.mcb_cmd_en}, 32'd0);
    tick();
    chk("calib_lat2_en", {31'd0, bus.mcb_cmd_en}, 32'd1);
    chk("calib_lat2_instr", {29'd0, bus.mcb_cmd_instr}, 32'd0);

    // Held requests: anti-starvation pattern and minimum command spacing
    do_reset();
    auto_drop = 1'b0;
    bus.calib_done = 1'b1; bus.mcb_wr_count = 7'd64; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 80 && grant_log.size() < 10; i++) tick();
    chk("pattern_count", grant_log.size(), 10);
    if (grant_log.size() >= 10) begin
      bit exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int g = 0; g < 10; g++)
        chk($sformatf("pattern_g%0d", g), {31'd0, grant_log[g]}, {31'd0, exp_pat[g]});
      chk("spacing", grant_cyc[1] - grant_cyc[0], 3);
    end

    // Read in-flight cap
    do_reset();
    bus.calib_done = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 30'h800;
    repeat (30) tick();
    chk("rd_cap_acks", n_rd_ack, 2);
    chk("rd_cap_idle", {31'd0, bus.arb_busy}, 32'd0);
    bus.rd_burst_done = 1'b1; tick(); bus.rd_burst_done = 1'b0;
    repeat (10) tick();
    chk("rd_after_done_acks", n_rd_ack, 3);
    bus.rd_burst_done = 1'b1; tick(); bus.rd_burst_done = 1'b0;
    wait_issue(found);
    bus.rd_burst_done = 1'b1; tick(); bus.rd_burst_done = 1'b0;
    chk("rd_done_with_issue_ack", {31'd0, bus.rd_ack}, 32'd1);
    n_rd_ack = 0;
    repeat (20) tick();
    chk("rd_after_same_cycle_acks", n_rd_ack, 1);

    // cmd_full stall, release, then async reset mid-ISSUE
    do_reset();
    auto_drop = 1'b1;
    bus.calib_done = 1'b1; bus.mcb_wr_count = 7'd64; bus.mcb_cmd_full = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 30'h1234;
    tick();
    repeat (10) tick();
    chk("full_no_cmd", n_cmd, 0);
    chk("full_busy", {31'd0, bus.arb_busy}, 32'd1);
    bus.mcb_cmd_full = 1'b0;
    repeat (8) tick();
    chk("full_release_cmd", n_cmd, 1);
    chk("full_release_ack", n_wr_ack, 1);
    bus.mcb_cmd_full = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 30'h2468;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {25'd0, bus.mcb_cmd_en, bus.wr_ack, bus.rd_ack, bus.arb_busy, bus.mcb_cmd_instr},
        32'd0);
    chk("async_rst_addr", {2'd0, bus.mcb_cmd_byte_addr}, 32'd0);
    chk("async_rst_bl", {26'd0, bus.mcb_cmd_bl}, 32'd63);

    // Async reset while mcb_cmd_en is high
    do_reset();
    bus.calib_done = 1'b1; bus.mcb_wr_count = 7'd64; bus.wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.mcb_cmd_en) found = 1'b1;
    end
    chk("pre_rst_cmd_en", {31'd0, found}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cmd_en", {30'd0, bus.mcb_cmd_en, bus.wr_ack}, 32'd0);

`ifdef DDR_ARB_STATS_EN
    do_reset();
    auto_drop = 1'b0;
    bus.calib_done = 1'b1; bus.mcb_wr_count = 7'd64; bus.mcb_cmd_full = 1'b1; bus.wr_req = 1'b1;
    tick();
    repeat (7) tick();
    bus.mcb_cmd_full = 1'b0;
    for (int i = 0; i < 60 && n_wr_ack < 5; i++) tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 60 && n_rd_ack < 3; i++) begin
      tick();
      bus.rd_burst_done = bus.rd_ack;
    end
    bus.rd_req = 1'b0;
    tick();
    bus.rd_burst_done = 1'b0;
    repeat (4) tick();
    chk("stat_wr", {16'd0, stat_wr_grants}, 32'd5);
    chk("stat_rd", {16'd0, stat_rd_grants}, 32'd3);
    chk("stat_stall", {16'd0, stat_stall_cycles}, 32'd7);
    bus.wr_req = 1'b1;
    wait_issue(found);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    bus.wr_req = 1'b0;
    chk("stat_clr_issue_ack", {31'd0, bus.wr_ack}, 32'd1);
    chk("stat_clr_all", {stat_wr_grants, stat_rd_grants} | {16'd0, stat_stall_cycles}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
